// File: rtl/address_unit_pkg.sv
// Shared constants for the address unit: data/tag widths, memory opcode encodings,
// the request FIFO entry layout and opcode classification helpers.
package address_unit_pkg;

    localparam int IDWidth       = 32;
    localparam int ROBWidth      = 4;
    localparam int AddressWidth  = 32;
    localparam int InstTypeWidth = 6;

    localparam logic [InstTypeWidth-1:0] NOP = 6'd0;
    localparam logic [InstTypeWidth-1:0] LB  = 6'd1;
    localparam logic [InstTypeWidth-1:0] LH  = 6'd2;
    localparam logic [InstTypeWidth-1:0] LW  = 6'd3;
    localparam logic [InstTypeWidth-1:0] LBU = 6'd4;
    localparam logic [InstTypeWidth-1:0] LHU = 6'd5;
    localparam logic [InstTypeWidth-1:0] SB  = 6'd6;
    localparam logic [InstTypeWidth-1:0] SH  = 6'd7;
    localparam logic [InstTypeWidth-1:0] SW  = 6'd8;

    typedef struct packed {
        logic                     valid;
        logic [InstTypeWidth-1:0] opcode;
        logic [AddressWidth-1:0]  addr;
        logic [ROBWidth-1:0]      dest;
        logic [ROBWidth-1:0]      qk;
        logic [IDWidth-1:0]       vk;
        logic                     misalign;
    } au_entry_t;

    function automatic logic is_mem_op(input logic [InstTypeWidth-1:0] op);
        return (op >= LB) && (op <= SW);
    endfunction

    function automatic logic is_load_op(input logic [InstTypeWidth-1:0] op);
        return (op >= LB) && (op <= LHU);
    endfunction

endpackage

// File: rtl/address_unit_au_agen.sv
// Effective-address adder plus alignment check for the address unit.
// Alignment check is built only when AU_MISALIGN_CHECK_EN is defined; otherwise misalign is 0.
module au_agen
    import address_unit_pkg::*;
(
    input  logic [IDWidth-1:0]       base,
    input  logic [IDWidth-1:0]       offset,
    input  logic [InstTypeWidth-1:0] opcode,
    output logic [AddressWidth-1:0]  addr,
    output logic                     misalign
);

    logic [IDWidth-1:0] sum;

    assign sum  = base + offset;
    assign addr = sum[AddressWidth-1:0];

`ifdef AU_MISALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        if (opcode == LH || opcode == LHU || opcode == SH)
            misalign = addr[0];
        else if (opcode == LW || opcode == SW)
            misalign = |addr[1:0];
    end
`else
    logic unused_opcode;
    assign unused_opcode = ^opcode;
    assign misalign      = 1'b0;
`endif

endmodule

// File: rtl/address_unit.sv
// Address unit: computes load/store addresses into an in-order request FIFO, snoops the
// CDB for pending store data and hands entries to the LSB. Option: AU_MISALIGN_CHECK_EN.
module address_unit
    import address_unit_pkg::*;
#(
    parameter int unsigned AU_DEPTH = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     rdy_in,
    input  logic                     rob_au_rst_in,
    input  logic [InstTypeWidth-1:0] rs_addrunit_opcode_in,
    input  logic [IDWidth-1:0]       rs_addrunit_a_in,
    input  logic [IDWidth-1:0]       rs_addrunit_vj_in,
    input  logic [IDWidth-1:0]       rs_addrunit_vk_in,
    input  logic [ROBWidth-1:0]      rs_addrunit_qk_in,
    input  logic [ROBWidth-1:0]      rs_addrunit_dest_in,
    output logic                     au_rs_rdy_out,
    input  logic                     cdb_au_en_in,
    input  logic [ROBWidth-1:0]      cdb_au_b_in,
    input  logic [IDWidth-1:0]       cdb_au_result_in,
    output logic                     au_lsb_valid_out,
    input  logic                     au_lsb_ready_in,
    output logic [AddressWidth-1:0]  au_lsb_addr_out,
    output logic [IDWidth-1:0]       au_lsb_data_out,
    output logic [ROBWidth-1:0]      au_lsb_dest_out,
    output logic [InstTypeWidth-1:0] au_lsb_opcode_out,
    output logic                     au_lsb_misalign_out
);

    localparam int PtrW = $clog2(AU_DEPTH);
    localparam int CntW = $clog2(AU_DEPTH + 1);

    au_entry_t             entries [AU_DEPTH];
    au_entry_t             head_e;
    au_entry_t             new_e;
    logic [PtrW-1:0]       head;
    logic [PtrW-1:0]       tail;
    logic [CntW-1:0]       count;
    logic                  empty;
    logic                  full;
    logic                  eligible;
    logic                  valid;
    logic                  push;
    logic                  pop;
    logic                  cdb_live;
    logic [AddressWidth-1:0] agen_addr;
    logic                  agen_misalign;

    au_agen u_agen (
        .base     (rs_addrunit_vj_in),
        .offset   (rs_addrunit_a_in),
        .opcode   (rs_addrunit_opcode_in),
        .addr     (agen_addr),
        .misalign (agen_misalign)
    );

    assign head_e   = entries[head];
    assign empty    = (count == '0);
    assign full     = (count == CntW'(AU_DEPTH));
    assign cdb_live = cdb_au_en_in && (cdb_au_b_in != '0);
    assign eligible = is_load_op(head_e.opcode) || (head_e.qk == '0);
    assign valid    = rdy_in && !rob_au_rst_in && !empty && eligible;
    assign pop      = valid && au_lsb_ready_in;
    assign push     = rdy_in && !rob_au_rst_in && is_mem_op(rs_addrunit_opcode_in) && !full;

    // An incoming request whose tag is being broadcast this cycle would otherwise miss it.
    always_comb begin
        new_e.valid    = 1'b1;
        new_e.opcode   = rs_addrunit_opcode_in;
        new_e.addr     = agen_addr;
        new_e.dest     = rs_addrunit_dest_in;
        new_e.qk       = rs_addrunit_qk_in;
        new_e.vk       = rs_addrunit_vk_in;
        new_e.misalign = agen_misalign;
        if (cdb_live && (cdb_au_b_in == rs_addrunit_qk_in)) begin
            new_e.qk = '0;
            new_e.vk = cdb_au_result_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < AU_DEPTH; i++)
                entries[i] <= '0;
        end else if (rdy_in) begin
            if (rob_au_rst_in) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                for (int unsigned i = 0; i < AU_DEPTH; i++)
                    entries[i].valid <= 1'b0;
            end else begin
                if (cdb_live) begin
                    for (int unsigned i = 0; i < AU_DEPTH; i++) begin
                        if (entries[i].valid && (entries[i].qk == cdb_au_b_in)) begin
                            entries[i].qk <= '0;
                            entries[i].vk <= cdb_au_result_in;
                        end
                    end
                end
                if (pop) begin
                    entries[head].valid <= 1'b0;
                    head                <= head + 1'b1;
                end
                if (push) begin
                    entries[tail] <= new_e;
                    tail          <= tail + 1'b1;
                end
                if (push && !pop)
                    count <= count + 1'b1;
                else if (pop && !push)
                    count <= count - 1'b1;
            end
        end
    end

    assign au_rs_rdy_out       = !full;
    assign au_lsb_valid_out    = valid;
    assign au_lsb_opcode_out   = valid ? head_e.opcode : NOP;
    assign au_lsb_addr_out     = head_e.addr;
    assign au_lsb_data_out     = head_e.vk;
    assign au_lsb_dest_out     = head_e.dest;
    assign au_lsb_misalign_out = valid && head_e.misalign;

endmodule
